// File: rtl/dsp_mac_pkg.sv
// Shared constants for the DSP48A1 multiply-accumulate sequencer.
// FSM encodings, OPMODE words and the fixed slice latency live here.
package dsp_mac_pkg;
    localparam int PIPE_LAT = 3;

    // X=M, Z=0 for the first product; X=M, Z=P for every later one
    localparam logic [7:0] OPMODE_FIRST = 8'h01;
    localparam logic [7:0] OPMODE_ACC   = 8'h09;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/dsp_mac_vpipe.sv
// Two-stage valid/first tracker that shadows the DSP A1->M->P register chain.
// v1 marks a live product entering M, f1 flags the first one, v2 a live P update.
module dsp_mac_vpipe (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    input  logic first,
    output logic v1,
    output logic f1,
    output logic v2
);
    logic v1_q, v1_d;
    logic f1_q, f1_d;
    logic v2_q, v2_d;

    always_comb begin
        v1_d = accept;
        f1_d = accept & first;
        v2_d = v1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            f1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            f1_q <= f1_d;
            v2_q <= v2_d;
        end
    end

    assign v1 = v1_q;
    assign f1 = f1_q;
    assign v2 = v2_q;
endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice (A1/B1/M/P/OPMODE registered) as a dot-product engine.
// in_valid/in_ready: a pair transfers on a rising edge where both are high; in_ready depends only on state.
module dsp_mac_sequencer
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W = 12
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    output logic [47:0]      res_data,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [7:0]       dsp_OPMODE,
    output logic             dsp_CEA,
    output logic             dsp_CEB,
    output logic             dsp_CEM,
    output logic             dsp_CEOPMODE,
    output logic             dsp_CEP,
    output logic             dsp_RSTP,
    output logic             dsp_RSTM,
    input  logic [47:0]      dsp_P,
    output logic [1:0]       dbg_state
);
    localparam logic [1:0] DRAIN_INIT = 2'(PIPE_LAT - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;
    logic [1:0]       drain_q, drain_d;
    logic             start_acc, accept;
    logic             v1, f1, v2;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign in_ready  = (state_q == ST_LOAD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        first_d = first_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = len;
                    first_d = 1'b1;
                    drain_d = DRAIN_INIT;
                    state_d = (len == '0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    rem_d   = rem_q - LEN_W'(1);
                    first_d = 1'b0;
                    if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
            end
            // Count out the slice latency so a zero-length run still reports on the same schedule
            ST_DRAIN: begin
                if (drain_q != 2'd0) drain_d = drain_q - 2'd1;
                else if (!v1 && !v2) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            first_q <= 1'b0;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            drain_q <= drain_d;
        end
    end

    dsp_mac_vpipe u_vpipe (
        .clk    (CLK),
        .rst_n  (RSTN),
        .accept (accept),
        .first  (first_q),
        .v1     (v1),
        .f1     (f1),
        .v2     (v2)
    );

    assign busy         = (state_q != ST_IDLE);
    assign res_valid    = (state_q == ST_DONE);
    assign res_data     = dsp_P;
    assign dsp_A        = in_a;
    assign dsp_B        = in_b;
    assign dsp_CEA      = accept;
    assign dsp_CEB      = accept;
    assign dsp_CEM      = v1;
    assign dsp_CEOPMODE = v1;
    assign dsp_CEP      = v2;
    assign dsp_OPMODE   = f1 ? OPMODE_FIRST : OPMODE_ACC;
    // Clearing P/M on the start cycle lets the first product load into a zeroed accumulator
    assign dsp_RSTP     = ~RSTN | start_acc;
    assign dsp_RSTM     = ~RSTN | start_acc;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1, synchronous resets) wired to its outputs.
module tb_dsp_mac_sequencer;
    localparam int LEN_W = 12;

    logic             CLK = 1'b0;
    logic             RSTN = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [17:0]      in_a = '0;
    logic [17:0]      in_b = '0;
    logic             res_valid;
    logic [47:0]      res_data;
    logic [17:0]      dsp_A, dsp_B;
    logic [7:0]       dsp_OPMODE;
    logic             dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEOPMODE, dsp_CEP;
    logic             dsp_RSTP, dsp_RSTM;
    logic [47:0]      dsp_P;
    logic [1:0]       dbg_state;

    dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_data(res_data),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE),
        .dsp_CEA(dsp_CEA), .dsp_CEB(dsp_CEB), .dsp_CEM(dsp_CEM),
        .dsp_CEOPMODE(dsp_CEOPMODE), .dsp_CEP(dsp_CEP),
        .dsp_RSTP(dsp_RSTP), .dsp_RSTM(dsp_RSTM), .dsp_P(dsp_P),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- DSP48A1 slice model ----------------
    logic signed [17:0] a1_r = '0, b1_r = '0;
    logic signed [35:0] m_r = '0;
    logic [7:0]         opm_r = '0;
    logic [47:0]        p_r = '0;
    always @(posedge CLK) begin
        if (dsp_CEA) a1_r <= dsp_A;
        if (dsp_CEB) b1_r <= dsp_B;
        if (dsp_RSTM) m_r <= '0;
        else if (dsp_CEM) m_r <= a1_r * b1_r;
        if (dsp_CEOPMODE) opm_r <= dsp_OPMODE;
        if (dsp_RSTP) p_r <= '0;
        else if (dsp_CEP)
            p_r <= ((opm_r[3:2] == 2'b10) ? p_r : 48'd0)
                 + ((opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0);
    end
    assign dsp_P = p_r;

    // ---------------- observation (opposite edge) ----------------
    int          rv_cnt = 0, rv_edge = 0, cep_cnt = 0, rdy_cnt = 0;
    logic [47:0] rv_data = '0;
    logic [7:0]  opm_log[$];
    always @(negedge CLK) begin
        if (res_valid) begin
            rv_cnt  = rv_cnt + 1;
            rv_edge = cyc;
            rv_data = res_data;
        end
        if (dsp_CEP) cep_cnt = cep_cnt + 1;
        if (in_ready) rdy_cnt = rdy_cnt + 1;
        if (dsp_CEOPMODE) opm_log.push_back(dsp_OPMODE);
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int rv_base, cep_base, rdy_base, opm_base;
    logic signed [17:0] va[$];
    logic signed [17:0] vb[$];

    // ---------------- driver ----------------
    task automatic do_run(input int n, input int gap, input bit poke, output int ref_edge, output bit tmo);
        int guard;
        tmo      = 1'b0;
        rv_base  = rv_cnt;
        cep_base = cep_cnt;
        rdy_base = rdy_cnt;
        opm_base = opm_log.size();
        start    = 1'b1;
        len      = LEN_W'(n);
        ref_edge = cyc + 1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int i = 0; i < n && !tmo; i++) begin
            if (i > 0) repeat (gap) begin @(posedge CLK); #1; end
            in_valid = 1'b1;
            in_a     = va[i];
            in_b     = vb[i];
            if (poke && i == 1) start = 1'b1;
            guard = 0;
            while (!in_ready && guard < 16) begin @(posedge CLK); #1; guard++; end
            if (!in_ready) tmo = 1'b1;
            else ref_edge = cyc + 1;
            @(posedge CLK); #1;
            in_valid = 1'b0;
            start    = 1'b0;
        end
        in_valid = 1'b0;
        guard = 0;
        while (rv_cnt == rv_base && guard < 20) begin @(posedge CLK); #1; guard++; end
        if (rv_cnt == rv_base) tmo = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_cmp++; if ({dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEOPMODE, dsp_CEP} !== 5'b0) begin n_bad++;
            $display("FAIL reset_ces: got %b want 00000", {dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEOPMODE, dsp_CEP}); end
        n_cmp++; if ({dsp_RSTP, dsp_RSTM} !== 2'b11) begin n_bad++; $display("FAIL reset_dsp_rst: got %b want 11", {dsp_RSTP, dsp_RSTM}); end
        n_cmp++; if (res_data !== 48'h0) begin n_bad++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        RSTN = 1'b1;
        @(posedge CLK); #1;
        // operands outside LOAD are passed through but never enabled
        in_valid = 1'b1; in_a = 18'h0007B; in_b = 18'h3FFFF;
        #1;
        n_cmp++; if ({dsp_RSTP, dsp_RSTM} !== 2'b00) begin n_bad++; $display("FAIL idle_dsp_rst: got %b want 00", {dsp_RSTP, dsp_RSTM}); end
        n_cmp++; if (dsp_A !== 18'h0007B || dsp_B !== 18'h3FFFF) begin n_bad++;
            $display("FAIL idle_passthru: got %h/%h want 0007b/3ffff", dsp_A, dsp_B); end
        n_cmp++; if (in_ready !== 1'b0 || dsp_CEA !== 1'b0) begin n_bad++;
            $display("FAIL idle_ignore_valid: got ready=%b cea=%b want 0/0", in_ready, dsp_CEA); end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        int re; bit tmo; int bad_acc;
        va = '{18'sd1, 18'sd3, 18'sd5, 18'sd7};
        vb = '{18'sd2, 18'sd4, 18'sd6, 18'sd8};
        do_run(4, 0, 1'b0, re, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", tmo); end
        n_cmp++; if (rv_cnt - rv_base !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", rv_cnt - rv_base); end
        n_cmp++; if (rv_edge !== re + 3) begin n_bad++; $display("FAIL basic_latency: got edge %0d want %0d", rv_edge, re + 3); end
        n_cmp++; if (rv_data !== 48'h64) begin n_bad++; $display("FAIL basic_data: got %h want 64", rv_data); end
        n_cmp++; if (cep_cnt - cep_base !== 4) begin n_bad++; $display("FAIL basic_cep: got %0d want 4", cep_cnt - cep_base); end
        n_cmp++; if (opm_log.size() - opm_base !== 4 || opm_log[opm_base] !== 8'h01) begin n_bad++;
            $display("FAIL basic_opmode_first: got n=%0d first=%h want n=4 first=01", opm_log.size() - opm_base, opm_log[opm_base]); end
        bad_acc = 0;
        for (int i = opm_base + 1; i < opm_log.size(); i++) if (opm_log[i] !== 8'h09) bad_acc++;
        n_cmp++; if (bad_acc !== 0) begin n_bad++; $display("FAIL basic_opmode_acc: got %0d non-09 words want 0", bad_acc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        n_cmp++; if (res_data !== 48'h64) begin n_bad++; $display("FAIL basic_hold: got %h want 64", res_data); end
    endtask

    task automatic test_negative();
        int re; bit tmo;
        va = '{-18'sd3, 18'sd2};
        vb = '{18'sd5, 18'sd7};
        do_run(2, 0, 1'b0, re, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL neg_timeout: got %b want 0", tmo); end
        n_cmp++; if (rv_data !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL neg_data: got %h want ffffffffffff", rv_data); end
        n_cmp++; if (rv_edge !== re + 3) begin n_bad++; $display("FAIL neg_latency: got edge %0d want %0d", rv_edge, re + 3); end
    endtask

    task automatic test_bubbles();
        int re; bit tmo;
        va = '{18'sd1, 18'sd3, 18'sd5, 18'sd7};
        vb = '{18'sd2, 18'sd4, 18'sd6, 18'sd8};
        do_run(4, 2, 1'b0, re, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL bubble_timeout: got %b want 0", tmo); end
        n_cmp++; if (rv_data !== 48'h64) begin n_bad++; $display("FAIL bubble_data: got %h want 64", rv_data); end
        n_cmp++; if (cep_cnt - cep_base !== 4) begin n_bad++; $display("FAIL bubble_cep: got %0d want 4", cep_cnt - cep_base); end
        n_cmp++; if (rv_cnt - rv_base !== 1) begin n_bad++; $display("FAIL bubble_pulses: got %0d want 1", rv_cnt - rv_base); end
        n_cmp++; if (rv_edge !== re + 3) begin n_bad++; $display("FAIL bubble_latency: got edge %0d want %0d", rv_edge, re + 3); end
    endtask

    task automatic test_len_zero();
        int re; bit tmo;
        do_run(0, 0, 1'b0, re, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL zero_timeout: got %b want 0", tmo); end
        n_cmp++; if (rv_data !== 48'h0) begin n_bad++; $display("FAIL zero_data: got %h want 0", rv_data); end
        n_cmp++; if (rv_edge !== re + 3) begin n_bad++; $display("FAIL zero_latency: got edge %0d want %0d", rv_edge, re + 3); end
        n_cmp++; if (rdy_cnt - rdy_base !== 0) begin n_bad++; $display("FAIL zero_in_ready: got %0d ready cycles want 0", rdy_cnt - rdy_base); end
        n_cmp++; if (rv_cnt - rv_base !== 1) begin n_bad++; $display("FAIL zero_pulses: got %0d want 1", rv_cnt - rv_base); end
    endtask

    task automatic test_start_ignored();
        int re; bit tmo;
        va = '{18'sd1, 18'sd1, 18'sd1};
        vb = '{18'sd1, 18'sd1, 18'sd1};
        do_run(3, 0, 1'b1, re, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL restart_timeout: got %b want 0", tmo); end
        n_cmp++; if (rv_data !== 48'h3) begin n_bad++; $display("FAIL restart_data: got %h want 3", rv_data); end
        n_cmp++; if (cep_cnt - cep_base !== 3) begin n_bad++; $display("FAIL restart_cep: got %0d want 3", cep_cnt - cep_base); end
        n_cmp++; if (rv_cnt - rv_base !== 1) begin n_bad++; $display("FAIL restart_pulses: got %0d want 1", rv_cnt - rv_base); end
    endtask

    task automatic test_abort();
        int re; bit tmo; int base;
        base  = rv_cnt;
        start = 1'b1; len = LEN_W'(4);
        @(posedge CLK); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 18'd5; in_b = 18'd5;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready_%0d: got %b want 1", i, in_ready); end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        @(posedge CLK); #1;
        RSTN = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if ({dsp_RSTP, dsp_RSTM} !== 2'b11) begin n_bad++; $display("FAIL abort_dsp_rst: got %b want 11", {dsp_RSTP, dsp_RSTM}); end
        @(posedge CLK); #1;
        RSTN = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        n_cmp++; if (rv_cnt - base !== 0) begin n_bad++; $display("FAIL abort_no_result: got %0d pulses want 0", rv_cnt - base); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %b want 0", busy); end
        va = '{18'sd9};
        vb = '{18'sd9};
        do_run(1, 0, 1'b0, re, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL after_abort_timeout: got %b want 0", tmo); end
        n_cmp++; if (rv_data !== 48'h51) begin n_bad++; $display("FAIL after_abort_data: got %h want 51", rv_data); end
        n_cmp++; if (rv_edge !== re + 3) begin n_bad++; $display("FAIL after_abort_latency: got edge %0d want %0d", rv_edge, re + 3); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_bubbles();
        test_len_zero();
        test_start_ignored();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
